// File: rtl/otter_branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters, zero-latency
// lookup, EX-stage update/mispredict detection, and saturating statistics counters.
module otter_branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_next_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_jump,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        upd_mispredict,
    output logic [31:0] upd_recover_pc,
    input  logic        bp_flush,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX;

    localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_BITS'(1);

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic                jump_q   [ENTRIES];

    logic [IDX-1:0]      if_idx;
    logic [TAG_W-1:0]    if_tag;
    logic                if_hit;
    logic [IDX-1:0]      upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_hit;
    logic [CTR_BITS-1:0] ctr_upd;
    logic                unused_pc_bits;

    assign if_idx  = if_pc[IDX+1:2];
    assign if_tag  = if_pc[31:IDX+2];
    assign upd_idx = upd_pc[IDX+1:2];
    assign upd_tag = upd_pc[31:IDX+2];

    // Word-aligned fetch: the byte-offset bits never select an entry.
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
    assign if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken   = if_hit && (jump_q[if_idx] || ctr_q[if_idx][CTR_BITS-1]);
    assign pred_next_pc = pred_taken ? target_q[if_idx] : if_pc + 32'd4;

    assign upd_hit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_mispredict = upd_valid && ((upd_pred_taken != upd_taken) ||
                                          (upd_taken && (upd_pred_target != upd_target)));
    assign upd_recover_pc = upd_taken ? upd_target : upd_pc + 32'd4;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        ctr_upd = ctr_q[upd_idx];
        if (upd_is_jump) begin
            ctr_upd = CTR_MAX;
        end else if (upd_taken) begin
            if (ctr_q[upd_idx] != CTR_MAX) ctr_upd = ctr_q[upd_idx] + CTR_BITS'(1);
        end else begin
            if (ctr_q[upd_idx] != '0) ctr_upd = ctr_q[upd_idx] - CTR_BITS'(1);
        end
    end

    // NOTE: the table is built from flops, not RAM, so it can be cleared in a single reset cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
                jump_q[i]   <= 1'b0;
            end
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            // Statistics count even when a flush discards the table update.
            if (upd_valid && (stat_branches != '1))
                stat_branches <= stat_branches + 32'd1;
            if (upd_mispredict && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + 32'd1;

            if (bp_flush) begin
                for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
            end else if (upd_valid) begin
                if (upd_hit) begin
                    ctr_q[upd_idx]  <= ctr_upd;
                    jump_q[upd_idx] <= upd_is_jump;
                    if (upd_taken) target_q[upd_idx] <= upd_target;
                end else if (upd_taken) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= upd_target;
                    jump_q[upd_idx]   <= upd_is_jump;
                    ctr_q[upd_idx]    <= upd_is_jump ? CTR_MAX : CTR_WEAK_T;
                end
            end
        end
    end

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Scoreboard bench for otter_branch_predictor: directed scenarios then random traffic,
// checked against an entry-level reference model of the predictor's rules.
module tb_otter_branch_predictor;

    localparam int ENTRIES  = 16;
    localparam int CTR_BITS = 2;
    localparam int IDX      = $clog2(ENTRIES);
    localparam int CMAX     = (1 << CTR_BITS) - 1;
    localparam int CHALF    = 1 << (CTR_BITS - 1);

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        upd_mispredict;
    logic [31:0] upd_recover_pc;
    logic        bp_flush;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    otter_branch_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS)) dut (
        .CLK(CLK), .RESET(RESET), .if_pc(if_pc), .pred_taken(pred_taken),
        .pred_next_pc(pred_next_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .upd_mispredict(upd_mispredict), .upd_recover_pc(upd_recover_pc),
        .bp_flush(bp_flush), .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        pt;
        logic [31:0] npc;
        logic        mis;
        logic [31:0] rec;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: one record per table slot, remembering the full PC word that owns it.
    bit          m_valid [ENTRIES];
    int unsigned m_owner [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    bit          m_jmp   [ENTRIES];
    longint      m_br, m_mp;
    bit          known = 0;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_owner[slot(pc)] == (pc >> (IDX + 2)));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_jmp[slot(pc)] || m_ctr[slot(pc)] >= CHALF);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are compared mid-cycle, away from the active edge.
    always @(negedge CLK) begin : monitor
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
            check("pred_next_pc", pred_next_pc, e.npc);
            check("upd_mispredict", {31'd0, upd_mispredict}, {31'd0, e.mis});
            check("upd_recover_pc", upd_recover_pc, e.rec);
            check("stat_branches", stat_branches, e.sb);
            check("stat_mispredicts", stat_mispredicts, e.sm);
        end
    end

    task automatic step(input bit rst, input bit flush, input logic [31:0] ipc,
                        input bit uv, input logic [31:0] upc, input bit jmp, input bit tk,
                        input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        exp_t e;
        bit   mis;
        int   s;
        @(posedge CLK); #1;
        RESET = rst; bp_flush = flush; if_pc = ipc; upd_valid = uv; upd_pc = upc;
        upd_is_jump = jmp; upd_taken = tk; upd_target = tgt;
        upd_pred_taken = ptk; upd_pred_target = ptgt;
        mis = uv && ((ptk != tk) || (tk && ptgt != tgt));
        if (known) begin
            e.pt  = m_taken(ipc);
            e.npc = m_next(ipc);
            e.mis = mis;
            e.rec = tk ? tgt : upc + 32'd4;
            e.sb  = 32'(m_br);
            e.sm  = 32'(m_mp);
            exp_q.push_back(e);
        end
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0; m_ctr[i] = CHALF - 1; m_jmp[i] = 0;
            end
            m_br = 0; m_mp = 0; known = 1;
        end else begin
            if (uv) m_br = (m_br < 64'hFFFF_FFFF) ? m_br + 1 : m_br;
            if (mis) m_mp = (m_mp < 64'hFFFF_FFFF) ? m_mp + 1 : m_mp;
            s = slot(upc);
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            end else if (uv && m_hit(upc)) begin
                if (jmp) m_ctr[s] = CMAX;
                else if (tk) m_ctr[s] = (m_ctr[s] + 1 > CMAX) ? CMAX : m_ctr[s] + 1;
                else m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
                if (tk) m_tgt[s] = tgt;
                m_jmp[s] = jmp;
            end else if (uv && tk) begin
                m_valid[s] = 1; m_owner[s] = upc >> (IDX + 2); m_tgt[s] = tgt;
                m_jmp[s] = jmp; m_ctr[s] = jmp ? CMAX : CHALF;
            end
        end
    endtask

    task automatic lookup(input logic [31:0] ipc);
        step(0, 0, ipc, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    // Resolve an instruction carrying the prediction the table gives for it right now.
    task automatic upd(input logic [31:0] upc, input bit tk, input logic [31:0] tgt,
                       input bit jmp, input logic [31:0] ipc);
        step(0, 0, ipc, 1, upc, jmp, tk, tgt, m_taken(upc), m_next(upc));
    endtask

    initial begin
        logic [31:0] pc, tgt, ipc;
        bit tk, jmp, ptk;
        RESET = 1; bp_flush = 0; if_pc = 0; upd_valid = 0; upd_pc = 0; upd_is_jump = 0;
        upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;

        step(1, 0, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        lookup(32'h100);                          // reset state, stats zero
        lookup(32'h3FC);
        upd(32'h100, 1, 32'h80, 0, 32'h100);      // same-cycle lookup sees old contents
        lookup(32'h100);                          // now taken to 0x80
        upd(32'h100, 0, 32'h0, 0, 32'h100);
        upd(32'h100, 0, 32'h0, 0, 32'h100);
        lookup(32'h100);                          // not taken
        repeat (4) upd(32'h100, 1, 32'h80, 0, 32'h100);
        upd(32'h100, 0, 32'h0, 0, 32'h100);
        lookup(32'h100);                          // saturated counter stays taken
        lookup(32'h140);                          // alias miss
        upd(32'h140, 1, 32'h300, 0, 32'h140);
        lookup(32'h100);                          // evicted
        lookup(32'h140);

        step(1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 32'h0, 1, 32'h50, 0, 1, 32'h200, 0, 32'h54);
        lookup(32'h0);                            // stats now 1/1

        step(0, 1, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
        lookup(32'h100);
        lookup(32'h140);
        upd(32'h20, 1, 32'h400, 1, 32'h20);
        lookup(32'h20);                           // JAL predicted immediately
        step(0, 1, 32'h20, 1, 32'h60, 0, 1, 32'h600, 0, 32'h64);   // flush drops update
        lookup(32'h60);
        upd(32'h80, 1, 32'h900, 0, 32'h80);
        step(1, 0, 32'h80, 1, 32'hA0, 0, 1, 32'hB00, 0, 32'hA4);   // reset drops update
        lookup(32'hA0);
        lookup(32'h80);

        for (int n = 0; n < 600; n++) begin
            pc  = (32'($urandom_range(1, 3)) << (IDX + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2);
            ipc = (32'($urandom_range(1, 3)) << (IDX + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2);
            if ($urandom_range(0, 3) == 0) ipc = pc;
            jmp = ($urandom_range(0, 5) == 0);
            tk  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
            tgt = {$urandom_range(0, 255) << 2};
            ptk = m_taken(pc);
            if ($urandom_range(0, 3) == 0) ptk = ~ptk;
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0), ipc,
                 ($urandom_range(0, 4) != 0), pc, jmp, tk, tgt, ptk,
                 ($urandom_range(0, 3) == 0) ? tgt : m_next(pc));
        end

        lookup(32'h0);
        @(posedge CLK); @(negedge CLK); #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/otter_branch_predictor.md
OTTER_BRANCH_PREDICTOR -- requirements
Module: otter_branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of predictor entries; SHALL be a power of two, 2..256.
REQ-002 Parameter CTR_BITS, default 2, saturating-counter width; SHALL be 1..4.
REQ-003 CLK  in  1  clock; all state SHALL update on posedge CLK.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 if_pc  in  32  fetch-stage PC being looked up.
REQ-006 pred_taken  out  1  predicted redirect for if_pc.
REQ-007 pred_next_pc  out  32  predicted next fetch PC.
REQ-008 upd_valid  in  1  EX-stage resolved control-flow instruction this cycle.
REQ-009 upd_pc  in  32  PC of the resolved instruction.
REQ-010 upd_is_jump  in  1  resolved instruction is JAL/JALR.
REQ-011 upd_taken  in  1  actual outcome.
REQ-012 upd_target  in  32  actual target.
REQ-013 upd_pred_taken  in  1  prediction carried down the pipe with the instruction.
REQ-014 upd_pred_target  in  32  predicted next PC carried down the pipe.
REQ-015 upd_mispredict  out  1  resolved outcome differs from prediction.
REQ-016 upd_recover_pc  out  32  correct next PC after a mispredict.
REQ-017 bp_flush  in  1  invalidate all entries (e.g. FENCE.I).
REQ-018 stat_branches  out  32  count of upd_valid cycles.
REQ-019 stat_mispredicts  out  32  count of upd_mispredict cycles.

Function
REQ-020 Index SHALL be pc[IDX+1:2], IDX=log2(ENTRIES); tag SHALL be pc[31:IDX+2].
REQ-021 Each entry SHALL hold valid, tag, 32-bit target, CTR_BITS counter, jump flag.
REQ-022 Lookup SHALL be combinational, zero latency: hit = valid && tag match at the if_pc index.
REQ-023 pred_taken SHALL be hit && (jump flag || counter MSB); pred_next_pc SHALL be the stored target when pred_taken, else if_pc+4 (mod 2^32).
REQ-024 upd_mispredict SHALL be upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_target != upd_target)); combinational.
REQ-025 upd_recover_pc SHALL be upd_target when upd_taken, else upd_pc+4.
REQ-026 On upd_valid with a tag hit: counter SHALL increment on taken and decrement on not-taken, saturating at 2^CTR_BITS-1 and 0; target SHALL be overwritten with upd_target when taken; jump flag SHALL be set to upd_is_jump.
REQ-027 On upd_valid with a miss and upd_taken=1: the entry SHALL be allocated (overwriting any aliasing entry) with valid=1, new tag, upd_target, jump flag=upd_is_jump, counter=2^(CTR_BITS-1) (weakly taken).
REQ-028 On upd_valid with a miss and upd_taken=0: no entry SHALL change.
REQ-029 For upd_is_jump=1 the counter SHALL be written to 2^CTR_BITS-1.
REQ-030 Lookup and update to the same index in one cycle: lookup SHALL return pre-update contents; the update SHALL be visible the following cycle.
REQ-031 bp_flush SHALL clear every valid bit in one cycle; an upd_valid in the same cycle SHALL be discarded; statistics SHALL still count it.
REQ-032 Statistic counters SHALL increment by one per qualifying cycle and saturate at 32'hFFFF_FFFF.
REQ-033 upd_mispredict and upd_recover_pc SHALL be valid regardless of bp_flush.

Reset
REQ-034 RESET SHALL clear all valid bits, set all counters to 2^(CTR_BITS-1)-1, clear jump flags, and zero both statistic counters; RESET SHALL take priority over bp_flush and update.
REQ-035 After RESET, pred_taken SHALL be 0 and pred_next_pc SHALL be if_pc+4 for every if_pc.
REQ-036 RESET asserted in the same cycle as upd_valid SHALL discard the update and not count it.

Verification (ENTRIES=16, CTR_BITS=2)
REQ-037 Reset, if_pc=0x100 -> pred_taken=0, pred_next_pc=0x104, stat counters 0.
REQ-038 Update pc=0x100 taken target=0x80 -> next cycle if_pc=0x100 gives pred_taken=1, pred_next_pc=0x80; two not-taken updates -> pred_taken=0; four taken updates -> counter saturates at 3, one not-taken keeps pred_taken=1.
REQ-039 After allocating 0x100, if_pc=0x140 (same index, different tag) -> pred_taken=0, pred_next_pc=0x144; taken update at 0x140 evicts 0x100.
REQ-040 upd_valid, upd_pred_taken=0, upd_taken=1, upd_target=0x200 -> upd_mispredict=1, upd_recover_pc=0x200; next cycle stat_mispredicts=1, stat_branches=1.
REQ-041 Same-cycle lookup and first taken update of 0x100 -> that cycle pred_taken=0; next cycle pred_taken=1.
REQ-042 bp_flush after allocations -> next cycle all lookups miss; JAL update pc=0x20 target=0x400 -> pred_taken=1 immediately on the next lookup of 0x20.
